clock_phase_monitor: RTL and testbench

- Receiving end of the three-phase clock generator.
- Samples cycle_clock, ram_clock and internal_clock on clk and decodes them into a registered phase index.
- Checks the cycle -> ram -> internal -> cycle ordering, detects halt stalls, overlap and order violations, and reports lock status.
- Sits beside the generator; the sequencer and debug logic use it to gate phase-dependent work.

---
 rtl/clock_phase_monitor_pkg.sv | 34 +++
 rtl/clock_phase_monitor_if.sv | 27 ++
 rtl/clock_phase_decode.sv | 26 ++
 rtl/clock_phase_monitor.sv | 155 +++++++++++++++
 tb/tb_clock_phase_monitor.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/clock_phase_monitor_pkg.sv
// Shared definitions for the three-phase clock monitor: phase encoding,
// event classification and lock state.
package clock_phase_pkg;

   localparam logic [1:0] PH_CYCLE    = 2'd0;
   localparam logic [1:0] PH_RAM      = 2'd1;
   localparam logic [1:0] PH_INTERNAL = 2'd2;
   localparam logic [1:0] PH_NONE     = 2'd3;

   typedef enum logic [2:0] {
      ADVANCE,
      HOLD,
      ORDER,
      IDLE,
      OVERLAP
   } event_t;

   typedef enum logic {
      UNLOCKED,
      LOCKED
   } state_t;

   // Legal successor of a valid phase in the cycle -> ram -> internal ring.
   function automatic logic [1:0] next_phase(input logic [1:0] ph);
      logic [1:0] nxt;
      case (ph)
         PH_CYCLE: nxt = PH_RAM;
         PH_RAM:   nxt = PH_INTERNAL;
         default:  nxt = PH_CYCLE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/clock_phase_monitor_if.sv
// Bundle of phase pulses, error clear and status outputs between the
// generator side (master) and the phase monitor (slave).
interface clock_phase_monitor_if #(
   parameter int ERR_W = 8
);
   logic             cycle_clock;
   logic             ram_clock;
   logic             internal_clock;
   logic             clear_err;
   logic [1:0]       phase;
   logic             phase_advance;
   logic             locked;
   logic             stalled;
   logic             err_order;
   logic             err_overlap;
   logic [ERR_W-1:0] err_count;

   modport master (
      output cycle_clock, ram_clock, internal_clock, clear_err,
      input  phase, phase_advance, locked, stalled, err_order, err_overlap, err_count
   );

   modport slave (
      input  cycle_clock, ram_clock, internal_clock, clear_err,
      output phase, phase_advance, locked, stalled, err_order, err_overlap, err_count
   );
endinterface

// File: rtl/clock_phase_decode.sv
// Maps the {internal, ram, cycle} pulse vector to a phase index plus
// overlap and none flags. Purely combinational.
module clock_phase_decode
   import clock_phase_pkg::*;
(
   input  logic [2:0] vec,
   output logic [1:0] phase,
   output logic       overlap,
   output logic       none
);

   // One-hot vector gives a valid index; anything else is NONE or OVERLAP.
   always_comb begin
      phase   = PH_NONE;
      overlap = 1'b0;
      none    = 1'b0;
      case (vec)
         3'b001:  phase   = PH_CYCLE;
         3'b010:  phase   = PH_RAM;
         3'b100:  phase   = PH_INTERNAL;
         3'b000:  none    = 1'b1;
         default: overlap = 1'b1;
      endcase
   end

endmodule

// File: rtl/clock_phase_monitor.sv
// Receiving end of the three-phase clock generator: decodes the phase
// pulses, checks their ordering, tracks lock and stall, and counts errors.
module clock_phase_monitor
   import clock_phase_pkg::*;
#(
   parameter int LOCK_CYCLES = 3,
   parameter int STALL_MAX   = 15,
   parameter int ERR_W       = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   clock_phase_monitor_if.slave bus
);

   localparam int LCW = $clog2(LOCK_CYCLES + 1);
   localparam int HCW = $clog2(STALL_MAX + 2);
   localparam logic [LCW-1:0] LOCK_TGT = LCW'(LOCK_CYCLES);
   localparam logic [HCW-1:0] HOLD_SAT = HCW'(STALL_MAX + 1);
   localparam logic [HCW-1:0] HOLD_LIM = HCW'(STALL_MAX);

   logic [1:0]       dec_phase;
   logic             dec_overlap;
   logic             dec_none;
   event_t           ev;
   logic             err_event;
   state_t           state;
   logic [LCW-1:0]   lock_cnt;
   logic [HCW-1:0]   hold_cnt;
   logic [HCW-1:0]   hold_next;
   logic [1:0]       prev_phase;
   logic             phase_advance;
   logic             locked;
   logic             stalled;
   logic             err_order;
   logic             err_overlap;
   logic [ERR_W-1:0] err_count;

   // Error counter sticks at all-ones instead of wrapping.
   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   clock_phase_decode u_decode (
      .vec     ({bus.internal_clock, bus.ram_clock, bus.cycle_clock}),
      .phase   (dec_phase),
      .overlap (dec_overlap),
      .none    (dec_none)
   );

   // Classify this sample against the previous decode; only cycle may follow NONE.
   always_comb begin
      ev = ORDER;
      if (dec_overlap)
         ev = OVERLAP;
      else if (dec_none)
         ev = IDLE;
      else if (prev_phase == PH_NONE)
         ev = (dec_phase == PH_CYCLE) ? ADVANCE : ORDER;
      else if (dec_phase == next_phase(prev_phase))
         ev = ADVANCE;
      else if (dec_phase == prev_phase)
         ev = HOLD;
      else
         ev = ORDER;
   end

   assign err_event = (ev == ORDER) || (ev == OVERLAP);
   assign hold_next = (ev != HOLD) ? '0 :
                      (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + 1'b1;

   // Registered phase index (also the reference for the next sample) and advance pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_phase    <= PH_NONE;
         phase_advance <= 1'b0;
      end else begin
         prev_phase    <= dec_phase;
         phase_advance <= (ev == ADVANCE);
      end
   end

   // Lock FSM: count consecutive advances (holds pause the count) until locked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= UNLOCKED;
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else begin
         case (state)
            UNLOCKED: begin
               case (ev)
                  ADVANCE: begin
                     if (lock_cnt + 1'b1 == LOCK_TGT) begin
                        state    <= LOCKED;
                        locked   <= 1'b1;
                        lock_cnt <= '0;
                     end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                     end
                  end
                  HOLD:    lock_cnt <= lock_cnt;
                  default: lock_cnt <= '0;
               endcase
            end
            default: begin
               if (ev == ORDER || ev == OVERLAP || ev == IDLE) begin
                  state    <= UNLOCKED;
                  locked   <= 1'b0;
                  lock_cnt <= '0;
               end
            end
         endcase
      end
   end

   // Halt length tracking; a long hold flags stalled but never drops lock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
         stalled  <= 1'b0;
      end else begin
         hold_cnt <= hold_next;
         stalled  <= (hold_next > HOLD_LIM);
      end
   end

   // Sticky error flags and counter; a coincident error beats clear_err.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_order   <= 1'b0;
         err_overlap <= 1'b0;
         err_count   <= '0;
      end else if (bus.clear_err) begin
         err_order   <= (ev == ORDER);
         err_overlap <= (ev == OVERLAP);
         err_count   <= err_event ? ERR_W'(1) : '0;
      end else begin
         if (ev == ORDER)
            err_order <= 1'b1;
         if (ev == OVERLAP)
            err_overlap <= 1'b1;
         if (err_event)
            err_count <= sat_inc(err_count);
      end
   end

   assign bus.phase         = prev_phase;
   assign bus.phase_advance = phase_advance;
   assign bus.locked        = locked;
   assign bus.stalled       = stalled;
   assign bus.err_order     = err_order;
   assign bus.err_overlap   = err_overlap;
   assign bus.err_count     = err_count;

endmodule

// File: tb/tb_clock_phase_monitor.sv
// Scoreboard bench for clock_phase_monitor: directed phase sequences push
// hand-computed expected outputs; a monitor pops and compares every clk.
module tb_clock_phase_monitor;

   localparam logic [2:0] VN = 3'b000;
   localparam logic [2:0] VC = 3'b001;
   localparam logic [2:0] VR = 3'b010;
   localparam logic [2:0] VI = 3'b100;

   typedef struct packed {
      logic [1:0] ph;
      logic       adv;
      logic       lk;
      logic       st;
      logic       eo;
      logic       ev;
      logic [7:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   int checks = 0;
   int fails  = 0;

   exp_t  exp_q[$];
   string name_q[$];

   clock_phase_monitor_if #(.ERR_W(8)) bus ();

   clock_phase_monitor #(
      .LOCK_CYCLES (3),
      .STALL_MAX   (15),
      .ERR_W       (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic exp_t actual();
      return {bus.phase, bus.phase_advance, bus.locked, bus.stalled,
              bus.err_order, bus.err_overlap, bus.err_count};
   endfunction

   task automatic compare(input string nm, input exp_t a, input exp_t e);
      checks++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got ph=%0d adv=%b lk=%b st=%b eo=%b ev=%b cnt=%0d, want ph=%0d adv=%b lk=%b st=%b eo=%b ev=%b cnt=%0d",
                  nm, a.ph, a.adv, a.lk, a.st, a.eo, a.ev, a.cnt,
                  e.ph, e.adv, e.lk, e.st, e.eo, e.ev, e.cnt);
      end
   endtask

   // Drive one sample and queue the output expected one clk later.
   task automatic step(input logic [2:0] vec, input logic clr, input string nm,
                       input logic [1:0] ph, input logic adv, input logic lk,
                       input logic st, input logic eo, input logic ev,
                       input logic [7:0] cnt);
      @(negedge clk);
      {bus.internal_clock, bus.ram_clock, bus.cycle_clock} = vec;
      bus.clear_err = clr;
      exp_q.push_back({ph, adv, lk, st, eo, ev, cnt});
      name_q.push_back(nm);
      @(posedge clk);
   endtask

   // Monitor: every clk the DUT presents a registered output word.
   initial begin
      exp_t  e;
      string n;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            compare(n, actual(), e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      {bus.internal_clock, bus.ram_clock, bus.cycle_clock} = VN;
      bus.clear_err = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      compare("reset_state", actual(), {2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
      @(negedge clk);
      rst = 1'b0;

      // Clean rotation: lock after the third advance.
      for (int i = 0; i < 9; i++)
         step((i % 3 == 0) ? VC : (i % 3 == 1) ? VR : VI, 1'b0, "rotate",
              2'(i % 3), 1'b1, (i >= 2), 1'b0, 1'b0, 1'b0, 8'd0);

      // Halt on ram for 20 clks; stall appears on the 16th hold.
      step(VC, 1'b0, "pre_hold", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      for (int j = 0; j < 20; j++)
         step(VR, 1'b0, "hold", 2'd1, (j == 0), 1'b1, (j >= 16), 1'b0, 1'b0, 8'd0);
      step(VI, 1'b0, "release", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

      // Order violation cycle -> internal, then relock.
      step(VC, 1'b0, "pre_order", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      step(VI, 1'b0, "order_err", 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
      step(VC, 1'b0, "relock_c",  2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
      step(VR, 1'b0, "relock_r",  2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
      step(VI, 1'b0, "relock_i",  2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);

      // Overlap of cycle and ram.
      step(VC | VR, 1'b0, "overlap", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2);

      // 300 order errors (ram after NONE), counter saturates at 255.
      for (int k = 0; k < 300; k++) begin
         step(VR, 1'b0, "sat_order", 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
              8'((3 + k > 255) ? 255 : 3 + k));
         step(VN, 1'b0, "sat_idle", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
              8'((3 + k > 255) ? 255 : 3 + k));
      end
      step(VN, 1'b1, "clear",       2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      step(VR, 1'b1, "clear_vs_err", 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);

      // Lock again, then asynchronous reset mid-stream.
      step(VN, 1'b0, "idle",  2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
      step(VC, 1'b0, "lk2_c", 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
      step(VR, 1'b0, "lk2_r", 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
      step(VI, 1'b0, "lk2_i", 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
      #3;
      {bus.internal_clock, bus.ram_clock, bus.cycle_clock} = VN;
      rst = 1'b1;
      #1;
      compare("async_reset", actual(), {2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
      @(negedge clk);
      rst = 1'b0;
      step(VR, 1'b0, "post_rst_ram",   2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
      step(VN, 1'b0, "post_rst_idle",  2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
      step(VC, 1'b0, "post_rst_cycle", 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
